// File: rtl/if_id_pipe_ctrl_pkg.sv
// Shared pipeline definitions: controller state encoding, IF/ID payload,
// NOP word, PC increment and a saturating counter helper.
package if_id_pipe_ctrl_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 16;

  // Fetch controller states
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FROZEN = 2'd1,
    ST_DONE   = 2'd2
  } pipe_state_e;

  localparam logic [XLEN-1:0] NOP_WORD = XLEN'(0);
  localparam logic [XLEN-1:0] PC_INC   = XLEN'(4);

  // IF/ID pipeline register payload
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc4;
    logic            valid;
  } if_id_t;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) return v;
    return v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/if_id_pipe_ctrl.sv
// IF stage PC register, IF/ID pipeline register and fetch control FSM.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   stall, flush          - hazard unit requests (stall has priority)
//   branch_target         - redirect PC used with flush
//   dbg_halt              - debug freeze request (level)
//   imem_instr/imem_addr  - instruction memory read data / fetch address (= pc)
//   if_id_instr/pc4/valid - IF/ID register contents
//   prog_done             - high once the halt opcode has been latched
//   stall_cnt/flush_cnt   - saturating event counters
module if_id_pipe_ctrl
  import if_id_pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] PC_RESET    = 32'h0000_0000,
  parameter logic [31:0] HALT_OPCODE = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] branch_target,
  input  logic        dbg_halt,
  input  logic [31:0] imem_instr,
  output logic [31:0] imem_addr,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        prog_done,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  pipe_state_e       state;
  logic [XLEN-1:0]   pc;
  if_id_t            if_id;
  logic [CNT_W-1:0]  stall_q;
  logic [CNT_W-1:0]  flush_q;
  logic [XLEN-1:0]   pc_plus4;
  logic              halt_hit;

  // Modulo-2^32 increment; wrap at the top of the address space is intended
  assign pc_plus4 = pc + PC_INC;
  assign halt_hit = (imem_instr == HALT_OPCODE);

  // State, PC, IF/ID register and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_RUN;
      pc      <= PC_RESET;
      if_id   <= '{instr: NOP_WORD, pc4: XLEN'(0), valid: 1'b0};
      stall_q <= CNT_W'(0);
      flush_q <= CNT_W'(0);
    end else begin
      case (state)
        ST_RUN: begin
          if (dbg_halt) begin
            // Freeze takes effect immediately: no fetch in this cycle
            state <= ST_FROZEN;
          end else if (stall) begin
            stall_q <= sat_inc(stall_q);
          end else if (flush) begin
            pc             <= branch_target;
            if_id.instr    <= NOP_WORD;
            if_id.valid    <= 1'b0;
            flush_q        <= sat_inc(flush_q);
          end else begin
            if_id.instr <= imem_instr;
            if_id.pc4   <= pc_plus4;
            if_id.valid <= 1'b1;
            // PC parks on the halt instruction's address
            if (halt_hit) begin
              state <= ST_DONE;
            end else begin
              pc <= pc_plus4;
            end
          end
        end
        ST_FROZEN: begin
          if (!dbg_halt) state <= ST_RUN;
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

  assign imem_addr   = pc;
  assign if_id_instr = if_id.instr;
  assign if_id_pc4   = if_id.pc4;
  assign if_id_valid = if_id.valid;
  assign stall_cnt   = stall_q;
  assign flush_cnt   = flush_q;
  assign prog_done   = (state == ST_DONE);

endmodule

// File: tb/tb_if_id_pipe_ctrl.sv
// Scoreboard bench for if_id_pipe_ctrl: a behavioural model predicts the
// outputs after every clock edge, a monitor compares them against the DUT.
module tb_if_id_pipe_ctrl;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, dbg_halt;
  logic [31:0] branch_target;
  logic [31:0] imem_instr, imem_addr;
  logic [31:0] if_id_instr, if_id_pc4;
  logic        if_id_valid, prog_done;
  logic [15:0] stall_cnt, flush_cnt;
  logic [31:0] halt_addr;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] pc, instr, pc4;
    logic        valid, done;
    logic [15:0] sc, fc;
  } exp_t;

  exp_t q[$];

  // Model state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_frozen, m_done;
  int          m_sc, m_fc;

  if_id_pipe_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .branch_target(branch_target), .dbg_halt(dbg_halt),
    .imem_instr(imem_instr), .imem_addr(imem_addr),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
    .prog_done(prog_done), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a, input logic [31:0] h);
    if (a == h) return HALT;
    return a ^ 32'h1234_5678;
  endfunction

  assign imem_instr = imem_word(imem_addr, halt_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid;
    e.done = m_done; e.sc = 16'(m_sc); e.fc = 16'(m_fc);
    return e;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    m_frozen = 1'b0; m_done = 1'b0; m_sc = 0; m_fc = 0;
  endtask

  // One clock of behaviour: drive inputs, predict, wait for the edge to be checked
  task automatic step(input logic s, input logic f, input logic [31:0] bt, input logic d);
    logic [31:0] w;
    @(negedge clk);
    stall = s; flush = f; branch_target = bt; dbg_halt = d;
    if (m_done) begin
      // halted until reset
    end else if (m_frozen) begin
      if (!d) m_frozen = 1'b0;
    end else if (d) begin
      m_frozen = 1'b1;
    end else if (s) begin
      if (m_sc < 65535) m_sc++;
    end else if (f) begin
      m_pc = bt; m_instr = 32'h0; m_valid = 1'b0;
      if (m_fc < 65535) m_fc++;
    end else begin
      w = imem_word(m_pc, halt_addr);
      m_instr = w; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
      if (w == HALT) m_done = 1'b1;
      else m_pc = m_pc + 32'd4;
    end
    q.push_back(snap());
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_pc"},    imem_addr, 32'h0);
    chk({tag, "_instr"}, if_id_instr, 32'h0);
    chk({tag, "_pc4"},   if_id_pc4, 32'h0);
    chk({tag, "_valid"}, 32'(if_id_valid), 32'h0);
    chk({tag, "_done"},  32'(prog_done), 32'h0);
    chk({tag, "_scnt"},  32'(stall_cnt), 32'h0);
    chk({tag, "_fcnt"},  32'(flush_cnt), 32'h0);
  endtask

  // Assert reset off-edge, check immediately, release away from a rising edge
  task automatic do_reset(input logic [31:0] h);
    stall = 1'b0; flush = 1'b0; dbg_halt = 1'b0; branch_target = 32'h0;
    reset = 1'b1;
    #1;
    model_reset();
    halt_addr = h;
    check_reset_values("reset");
    @(posedge clk); #2;
    reset = 1'b0;
  endtask

  // Monitor: compare DUT against the oldest prediction after each edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pc",    imem_addr, e.pc);
      chk("instr", if_id_instr, e.instr);
      chk("pc4",   if_id_pc4, e.pc4);
      chk("valid", 32'(if_id_valid), 32'(e.valid));
      chk("done",  32'(prog_done), 32'(e.done));
      chk("scnt",  32'(stall_cnt), 32'(e.sc));
      chk("fcnt",  32'(flush_cnt), 32'(e.fc));
    end
  end

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; dbg_halt = 1'b0;
    branch_target = 32'h0; halt_addr = 32'hFFFF_FFF0;
    #12;
    do_reset(32'hFFFF_FFF0);

    // Sequential fetch: four edges reach pc=0x10
    repeat (4) step(0, 0, 32'h0, 0);
    chk("seq_pc", imem_addr, 32'h10);
    chk("seq_pc4", if_id_pc4, 32'h10);

    // Stall at pc=0x8 for two cycles, then resume
    do_reset(32'hFFFF_FFF0);
    repeat (2) step(0, 0, 32'h0, 0);
    repeat (2) step(1, 0, 32'h0, 0);
    chk("stall_cnt2", 32'(stall_cnt), 32'd2);
    step(0, 0, 32'h0, 0);

    // Flush to 0x40, then stall+flush together (stall wins)
    step(0, 1, 32'h40, 0);
    chk("flush_pc", imem_addr, 32'h40);
    step(1, 1, 32'h80, 0);
    step(0, 0, 32'h0, 0);

    // PC wrap at the top of the address space
    step(0, 1, 32'hFFFF_FFF8, 0);
    repeat (3) step(0, 0, 32'h0, 0);
    chk("wrap_pc", imem_addr, 32'h4);

    // Halt at 0x0C; debug toggles afterwards have no effect
    do_reset(32'h0000_000C);
    repeat (4) step(0, 0, 32'h0, 0);
    chk("halt_pc", imem_addr, 32'h0C);
    step(0, 0, 32'h0, 1);
    step(0, 1, 32'h40, 0);
    step(0, 0, 32'h0, 1);
    step(0, 0, 32'h0, 0);

    // Freeze with flush, then reset asserted mid-freeze
    do_reset(32'hFFFF_FFF0);
    repeat (3) step(0, 0, 32'h0, 0);
    repeat (3) step(0, 1, 32'h40, 1);
    do_reset(32'hFFFF_FFF0);
    step(0, 0, 32'h0, 0);

    // Randomized runs
    for (int blk = 0; blk < 6; blk++) begin
      logic d;
      d = 1'b0;
      do_reset(($urandom_range(0, 1) == 1) ? 32'h0000_0030 : 32'hFFFF_FFF0);
      for (int i = 0; i < 250; i++) begin
        logic s, f;
        logic [31:0] bt;
        s = ($urandom_range(0, 99) < 20);
        f = ($urandom_range(0, 99) < 15);
        bt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : {20'h0, 10'($urandom), 2'b00};
        if ($urandom_range(0, 99) < 8) d = ~d;
        step(s, f, bt, d);
      end
    end

    // Stall counter saturation
    do_reset(32'hFFFF_FFF0);
    repeat (65540) step(1, 0, 32'h0, 0);
    chk("stall_sat", 32'(stall_cnt), 32'h0000_FFFF);
    step(0, 1, 32'h100, 0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #3;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d predictions left, required 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_pipe_ctrl.md
IF_ID_PIPE_CTRL -- requirements
Module: if_id_pipe_ctrl

Interface
REQ-001 SHALL have parameter PC_RESET, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter HALT_OPCODE, default 32'hFFFF_FFFF, meaning the instruction word that ends the program.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-005 SHALL have port stall, input, 1, load-use stall request from the hazard unit.
REQ-006 SHALL have port flush, input, 1, taken-branch flush request from the hazard unit.
REQ-007 SHALL have port branch_target, input, 32, redirect PC, valid while flush=1.
REQ-008 SHALL have port dbg_halt, input, 1, debug-unit freeze request (level).
REQ-009 SHALL have port imem_instr, input, 32, combinational instruction-memory read data for imem_addr.
REQ-010 SHALL have port imem_addr, output, 32, fetch address, equal to pc.
REQ-011 SHALL have ports if_id_instr (output, 32), if_id_pc4 (output, 32) and if_id_valid (output, 1), the IF/ID register contents.
REQ-012 SHALL have port prog_done, output, 1, high once HALT_OPCODE has been latched.
REQ-013 SHALL have ports stall_cnt (output, 16) and flush_cnt (output, 16), saturating event counters.

Function
REQ-014 SHALL implement FSM states RUN, FROZEN, DONE; reset state RUN.
REQ-015 SHALL move RUN->FROZEN when dbg_halt=1, FROZEN->RUN when dbg_halt=0, and RUN->DONE in the cycle the IF/ID register latches HALT_OPCODE with valid=1.
REQ-016 SHALL leave DONE only on reset; in DONE, pc and the IF/ID register hold and dbg_halt is ignored.
REQ-017 SHALL freeze pc, the IF/ID register and both counters while in FROZEN, ignoring stall and flush.
REQ-018 SHALL apply, in RUN, this per-cycle priority: stall > flush > normal fetch.
REQ-019 SHALL on stall in RUN hold pc and the IF/ID register unchanged and increment stall_cnt.
REQ-020 SHALL on flush without stall in RUN load pc<=branch_target, clear if_id_instr to 32'h0, set if_id_valid=0, keep if_id_pc4, and increment flush_cnt.
REQ-021 SHALL on normal fetch in RUN load if_id_instr<=imem_instr, if_id_pc4<=pc+4, if_id_valid<=1, and pc<=pc+4.
REQ-022 SHALL stop advancing pc in the fetch that latches HALT_OPCODE, so pc stays at that instruction's address.
REQ-023 SHALL compute pc+4 modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-024 SHALL saturate stall_cnt and flush_cnt at 16'hFFFF.
REQ-025 SHALL assert prog_done combinationally from state==DONE.

Reset
REQ-026 SHALL on reset asynchronously set pc=PC_RESET, if_id_instr=0, if_id_pc4=0, if_id_valid=0, stall_cnt=0, flush_cnt=0, state=RUN, prog_done=0.
REQ-027 SHALL abort any state, including FROZEN and DONE, on reset, and SHALL fetch from PC_RESET in the first edge after reset is released.

Structure
REQ-028 SHALL take the FSM state encoding, NOP word (32'h0) and PC increment (4) from the shared pipeline package.
REQ-029 SHALL be one module with no sub-modules; the IF/ID register and PC register live inside it.

Verification
REQ-030 SHALL check sequential fetch: after reset with imem returning addr-derived words, 4 edges -> pc=32'h10, if_id_pc4=32'h10, if_id_valid=1.
REQ-031 SHALL check stall: stall=1 for 2 cycles at pc=32'h8 -> pc and IF/ID unchanged for 2 edges, stall_cnt=2, fetch resumes at 32'h8.
REQ-032 SHALL check flush: flush=1, branch_target=32'h40 -> next edge pc=32'h40, if_id_instr=0, if_id_valid=0, flush_cnt=1.
REQ-033 SHALL check simultaneous stall=1 and flush=1 -> stall wins: pc held, flush_cnt unchanged, stall_cnt+1.
REQ-034 SHALL check halt: imem returns 32'hFFFF_FFFF at 32'h0C -> prog_done=1 next edge, pc stays 32'h0C thereafter; dbg_halt toggle has no effect until reset.
REQ-035 SHALL check freeze and reset: dbg_halt=1 for 3 cycles with flush=1 -> no state change; reset asserted mid-freeze -> all outputs at reset values immediately, without waiting for an edge.
